// File: rtl/floyd_pkg.sv
// ----------------------------------------------------------------------------
// floyd_pkg
//   Shared definitions for the Floyd-Warshall kernel: default matrix geometry,
//   the controller state encoding and the row/column -> word address helper.
//   No ports (package).
// ----------------------------------------------------------------------------
package floyd_pkg;

    localparam int N        = 128;  // matrix dimension, power of two
    localparam int ADDR_WID = 14;   // log2(N*N)
    localparam int DATA_WID = 32;   // signed distance word

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_IK,
        S_WAIT_IK,
        S_RD,
        S_CMP,
        S_DONE
    } fw_state_e;

    // Word address of element (row,col). N is a power of two, so row*N+col
    // is the concatenation {row,col}; lg_n is log2(N).
    function automatic logic [31:0] idx(input logic [15:0] row,
                                        input logic [15:0] col,
                                        input int          lg_n);
        return (32'(row) << lg_n) | 32'(col);
    endfunction

endpackage

// File: rtl/fw_minplus.sv
// ----------------------------------------------------------------------------
// fw_minplus
//   Combinational relaxation step of Floyd-Warshall:
//     sum = ik + kj            (two's complement, wraps at DATA_WID bits)
//     min = (ij < sum) ? ij : sum   (signed compare)
// Ports
//   i_ik   [DATA_WID]  distance i->k
//   i_kj   [DATA_WID]  distance k->j
//   i_ij   [DATA_WID]  current distance i->j
//   o_sum  [DATA_WID]  wrapped sum ik+kj
//   o_min  [DATA_WID]  relaxed distance i->j
// ----------------------------------------------------------------------------
module fw_minplus #(
    parameter int DATA_WID = floyd_pkg::DATA_WID
) (
    input  logic [DATA_WID-1:0] i_ik,
    input  logic [DATA_WID-1:0] i_kj,
    input  logic [DATA_WID-1:0] i_ij,
    output logic [DATA_WID-1:0] o_sum,
    output logic [DATA_WID-1:0] o_min
);

    logic [DATA_WID-1:0] w_sum;

    // Deliberately no overflow saturation: the result must match a 32-bit
    // C int loop bit-for-bit, wrapped sums included.
    assign w_sum = i_ik + i_kj;
    assign o_sum = w_sum;

    // Ties select the sum; both operands are equal then, so either is fine.
    assign o_min = ($signed(i_ij) < $signed(w_sum)) ? i_ij : w_sum;

endmodule

// File: rtl/kernel_floyd_warshall.sv
// ----------------------------------------------------------------------------
// kernel_floyd_warshall
//   In-place all-pairs shortest path over an N x N matrix of signed distances
//   held in external dual-port memory "path":
//     for k, for i, for j: path[i][j] = min(path[i][j], path[i][k]+path[k][j])
//   Started and finished through an ap_ctrl_hs handshake.
//
//   Per (k,i) the controller reads path[i][k] once into r_ik, then for every j
//   spends two cycles: RD issues path[k][j] on port0 and path[i][j] on port1,
//   CMP relaxes and writes path[i][j] back through port0.
//   Cycles per run: N*N*(2+2N) + 2.
//
// Ports
//   ap_clk          in   clock (mod_clk)
//   ap_rst          in   asynchronous active-high reset
//   ap_start        in   start request (level, sampled only in IDLE)
//   ap_done         out  one-cycle pulse when the matrix update is complete
//   ap_idle         out  high while in IDLE
//   ap_ready        out  one-cycle pulse, same cycle as ap_done
//   path_address0   out  port0 word address (row*N+col)
//   path_ce0        out  port0 access enable
//   path_we0        out  port0 write enable (only with ce0)
//   path_d0         out  port0 write data
//   path_q0         in   port0 read data, valid one cycle after the read
//   path_address1   out  port1 word address
//   path_ce1        out  port1 access enable
//   path_we1        out  port1 write enable, always 0 (port1 is read-only)
//   path_d1         out  port1 write data, always 0
//   path_q1         in   port1 read data, valid one cycle after the read
// ----------------------------------------------------------------------------
module kernel_floyd_warshall #(
    parameter int N        = floyd_pkg::N,
    parameter int ADDR_WID = floyd_pkg::ADDR_WID,
    parameter int DATA_WID = floyd_pkg::DATA_WID
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic                ap_start,
    output logic                ap_done,
    output logic                ap_idle,
    output logic                ap_ready,
    output logic [ADDR_WID-1:0] path_address0,
    output logic                path_ce0,
    output logic                path_we0,
    output logic [DATA_WID-1:0] path_d0,
    input  logic [DATA_WID-1:0] path_q0,
    output logic [ADDR_WID-1:0] path_address1,
    output logic                path_ce1,
    output logic                path_we1,
    output logic [DATA_WID-1:0] path_d1,
    input  logic [DATA_WID-1:0] path_q1
);

    import floyd_pkg::*;

    localparam int LG_N = $clog2(N);

    // ------------------------------------------------------------------
    // State and loop indices
    // ------------------------------------------------------------------
    fw_state_e           r_state;
    fw_state_e           w_state_nxt;
    logic [LG_N-1:0]     r_k;
    logic [LG_N-1:0]     r_i;
    logic [LG_N-1:0]     r_j;
    logic [DATA_WID-1:0] r_ik;

    logic                w_j_last;
    logic                w_i_last;
    logic                w_k_last;
    logic [DATA_WID-1:0] w_sum;
    logic [DATA_WID-1:0] w_min;
    logic [ADDR_WID-1:0] w_addr_ik;
    logic [ADDR_WID-1:0] w_addr_kj;
    logic [ADDR_WID-1:0] w_addr_ij;

    assign w_j_last = (r_j == LG_N'(N - 1));
    assign w_i_last = (r_i == LG_N'(N - 1));
    assign w_k_last = (r_k == LG_N'(N - 1));

    assign w_addr_ik = ADDR_WID'(idx(16'(r_i), 16'(r_k), LG_N));
    assign w_addr_kj = ADDR_WID'(idx(16'(r_k), 16'(r_j), LG_N));
    assign w_addr_ij = ADDR_WID'(idx(16'(r_i), 16'(r_j), LG_N));

    // ------------------------------------------------------------------
    // Relaxation datapath. In CMP, q0 holds path[k][j] and q1 holds
    // path[i][j], both read during the preceding RD cycle.
    // ------------------------------------------------------------------
    fw_minplus #(
        .DATA_WID (DATA_WID)
    ) u_minplus (
        .i_ik  (r_ik),
        .i_kj  (path_q0),
        .i_ij  (path_q1),
        .o_sum (w_sum),
        .o_min (w_min)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement or block order.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Loop indices and the cached path[i][k]
    // ------------------------------------------------------------------
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_k  <= '0;
            r_i  <= '0;
            r_j  <= '0;
            r_ik <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ap_start) begin
                        r_k <= '0;
                        r_i <= '0;
                        r_j <= '0;
                    end
                end
                S_WAIT_IK: begin
                    r_ik <= path_q0;
                end
                S_CMP: begin
                    // Column k of row i is being rewritten; later j in the
                    // same row must see the new path[i][k], as the C loop does.
                    if (r_j == r_k) begin
                        r_ik <= w_min;
                    end
                    // Indices are exactly LG_N bits wide, so the increments
                    // wrap to zero on their own at N-1.
                    r_j <= r_j + 1'b1;
                    if (w_j_last) begin
                        r_i <= r_i + 1'b1;
                        if (w_i_last) begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next state, handshake and memory port drive
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned (which would infer a latch).
    always_comb begin
        w_state_nxt   = r_state;
        ap_idle       = 1'b0;
        ap_done       = 1'b0;
        ap_ready      = 1'b0;
        path_ce0      = 1'b0;
        path_we0      = 1'b0;
        path_address0 = '0;
        path_d0       = '0;
        path_ce1      = 1'b0;
        path_we1      = 1'b0;
        path_address1 = '0;
        path_d1       = '0;

        case (r_state)
            S_IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    w_state_nxt = S_RD_IK;
                end
            end

            S_RD_IK: begin
                path_ce0      = 1'b1;
                path_address0 = w_addr_ik;
                w_state_nxt   = S_WAIT_IK;
            end

            S_WAIT_IK: begin
                w_state_nxt = S_RD;
            end

            S_RD: begin
                path_ce0      = 1'b1;
                path_address0 = w_addr_kj;
                path_ce1      = 1'b1;
                path_address1 = w_addr_ij;
                w_state_nxt   = S_CMP;
            end

            S_CMP: begin
                // Written back unconditionally: one write per (k,i,j) keeps
                // the schedule fixed and independent of the data.
                path_ce0      = 1'b1;
                path_we0      = 1'b1;
                path_address0 = w_addr_ij;
                path_d0       = w_min;
                if (w_j_last && w_i_last && w_k_last) begin
                    w_state_nxt = S_DONE;
                end else if (w_j_last) begin
                    w_state_nxt = S_RD_IK;
                end else begin
                    w_state_nxt = S_RD;
                end
            end

            S_DONE: begin
                ap_done     = 1'b1;
                ap_ready    = 1'b1;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // The wrapped sum is exposed by the datapath for debug; only the
    // selected minimum is stored.
    logic w_sum_unused;
    assign w_sum_unused = ^w_sum;

endmodule

// File: tb/tb_kernel_floyd_warshall.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_kernel_floyd_warshall
//   Two kernel instances (N=4 and N=2) sharing clock and reset, each with its
//   own one-cycle-latency dual-port memory model and protocol counters.
// ----------------------------------------------------------------------------
module tb_kernel_floyd_warshall;

    localparam int BUDGET = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start4;
    logic start2;

    // N=4 instance
    logic        done4, idle4, ready4;
    logic [3:0]  a0_4, a1_4;
    logic        ce0_4, we0_4, ce1_4, we1_4;
    logic [31:0] d0_4, d1_4, q0_4, q1_4;

    // N=2 instance
    logic        done2, idle2, ready2;
    logic [1:0]  a0_2, a1_2;
    logic        ce0_2, we0_2, ce1_2, we1_2;
    logic [31:0] d0_2, d1_2, q0_2, q1_2;

    // Memories and their load port
    logic [31:0] mem4 [16];
    logic [31:0] mem2 [4];
    logic        ld_en  = 1'b0;
    logic        ld_sel = 1'b0;
    logic [3:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;

    // Protocol counters (monotonic; tests compare differences)
    int rd0_4 = 0, rd1_4 = 0, wr_4 = 0, bad_4 = 0;
    int rd0_2 = 0, rd1_2 = 0, wr_2 = 0, bad_2 = 0;

    int n_pass  = 0;
    int n_total = 0;

    // C-loop reference matrix (first n*n entries used)
    int ref_m [16];

    kernel_floyd_warshall #(.N(4), .ADDR_WID(4), .DATA_WID(32)) u_dut4 (
        .ap_clk        (clk),
        .ap_rst        (rst),
        .ap_start      (start4),
        .ap_done       (done4),
        .ap_idle       (idle4),
        .ap_ready      (ready4),
        .path_address0 (a0_4),
        .path_ce0      (ce0_4),
        .path_we0      (we0_4),
        .path_d0       (d0_4),
        .path_q0       (q0_4),
        .path_address1 (a1_4),
        .path_ce1      (ce1_4),
        .path_we1      (we1_4),
        .path_d1       (d1_4),
        .path_q1       (q1_4)
    );

    kernel_floyd_warshall #(.N(2), .ADDR_WID(2), .DATA_WID(32)) u_dut2 (
        .ap_clk        (clk),
        .ap_rst        (rst),
        .ap_start      (start2),
        .ap_done       (done2),
        .ap_idle       (idle2),
        .ap_ready      (ready2),
        .path_address0 (a0_2),
        .path_ce0      (ce0_2),
        .path_we0      (we0_2),
        .path_d0       (d0_2),
        .path_q0       (q0_2),
        .path_address1 (a1_2),
        .path_ce1      (ce1_2),
        .path_we1      (we1_2),
        .path_d1       (d1_2),
        .path_q1       (q1_2)
    );

    // Memory models: read data on q one cycle after ce=1,we=0; write on ce=1,we=1.
    always @(posedge clk) begin
        if (ld_en) begin
            if (ld_sel) mem2[ld_addr[1:0]] <= ld_data;
            else        mem4[ld_addr]      <= ld_data;
        end
        if (ce0_4 === 1'b1) begin
            if (we0_4 === 1'b1) begin
                mem4[a0_4] <= d0_4;
                wr_4 <= wr_4 + 1;
            end else begin
                q0_4 <= mem4[a0_4];
                rd0_4 <= rd0_4 + 1;
            end
        end
        if (ce1_4 === 1'b1) begin
            q1_4 <= mem4[a1_4];
            rd1_4 <= rd1_4 + 1;
        end
        if (ce0_2 === 1'b1) begin
            if (we0_2 === 1'b1) begin
                mem2[a0_2] <= d0_2;
                wr_2 <= wr_2 + 1;
            end else begin
                q0_2 <= mem2[a0_2];
                rd0_2 <= rd0_2 + 1;
            end
        end
        if (ce1_2 === 1'b1) begin
            q1_2 <= mem2[a1_2];
            rd1_2 <= rd1_2 + 1;
        end
        // Illegal: any port1 write, write enable without ce, traffic while idle.
        if (we1_4 === 1'b1 || (we0_4 === 1'b1 && ce0_4 !== 1'b1) ||
            (idle4 === 1'b1 && (ce0_4 === 1'b1 || ce1_4 === 1'b1)))
            bad_4 <= bad_4 + 1;
        if (we1_2 === 1'b1 || (we0_2 === 1'b1 && ce0_2 !== 1'b1) ||
            (idle2 === 1'b1 && (ce0_2 === 1'b1 || ce1_2 === 1'b1)))
            bad_2 <= bad_2 + 1;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all return at posedge + #1)
    // ------------------------------------------------------------------
    task automatic ld(input bit sel, input int addr, input logic [31:0] data);
        ld_sel  = sel;
        ld_addr = 4'(addr);
        ld_data = data;
        ld_en   = 1'b1;
        @(posedge clk); #1;
        ld_en   = 1'b0;
    endtask

    task automatic ref_fw(input int n);
        for (int k = 0; k < n; k++)
            for (int i = 0; i < n; i++)
                for (int j = 0; j < n; j++) begin
                    int s;
                    s = ref_m[i*n+k] + ref_m[k*n+j];
                    if (s < ref_m[i*n+j]) ref_m[i*n+j] = s;
                end
    endtask

    // Loads the 4-node chain graph into mem4 and computes its reference.
    task automatic load_chain4();
        for (int a = 0; a < 16; a++) begin
            int v;
            v = ((a / 4) == (a % 4)) ? 0 : 999;
            if (a == 1)  v = 5;    // 0->1
            if (a == 6)  v = 3;    // 1->2
            if (a == 11) v = 1;    // 2->3
            if (a == 3)  v = 20;   // 0->3
            ref_m[a] = v;
            ld(1'b0, a, 32'(v));
        end
        ref_fw(4);
    endtask

    task automatic load2(input int v0, input int v1, input int v2, input int v3);
        ref_m[0] = v0; ref_m[1] = v1; ref_m[2] = v2; ref_m[3] = v3;
        for (int a = 0; a < 4; a++) ld(1'b1, a, 32'(ref_m[a]));
        ref_fw(2);
    endtask

    // One-cycle start pulse; cyc counts the IDLE cycle as 1 and ends on the
    // cycle ap_done is seen (-1 on timeout).
    task automatic run_pulse(input bit sel, output int cyc);
        if (sel) start2 = 1'b1; else start4 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        start4 = 1'b0;
        cyc = 2;
        while ((sel ? done2 : done4) !== 1'b1 && cyc < BUDGET) begin
            @(posedge clk); #1;
            cyc++;
        end
        if ((sel ? done2 : done4) !== 1'b1) cyc = -1;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        start4 = 1'b0;
        start2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (idle4 !== 1'b1) $display("FAIL reset_idle: got %b want 1", idle4); else n_pass++;
        n_total++; if (done4 !== 1'b0 || ready4 !== 1'b0) $display("FAIL reset_done_ready: got %b%b want 00", done4, ready4); else n_pass++;
        n_total++; if ({ce0_4, ce1_4, we0_4, we1_4} !== 4'b0000) $display("FAIL reset_ce_we: got %b want 0000", {ce0_4, ce1_4, we0_4, we1_4}); else n_pass++;
        n_total++; if (a0_4 !== 4'd0 || d0_4 !== 32'd0) $display("FAIL reset_addr_data: got a=%0d d=%0d want 0 0", a0_4, d0_4); else n_pass++;
        n_total++; if (idle2 !== 1'b1 || {ce0_2, ce1_2} !== 2'b00) $display("FAIL reset_dut2: got idle=%b ce=%b%b want 1 00", idle2, ce0_2, ce1_2); else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
        n_total++; if ({ce0_4, ce1_4} !== 2'b00 || idle4 !== 1'b1) $display("FAIL post_reset_quiet: got ce=%b%b idle=%b want 00 1", ce0_4, ce1_4, idle4); else n_pass++;
    endtask

    task automatic test_shortest_path();
        int cyc, r0, r1, w, b, diffs;
        load_chain4();
        r0 = rd0_4; r1 = rd1_4; w = wr_4; b = bad_4;
        run_pulse(1'b0, cyc);
        n_total++; if (cyc !== 162) $display("FAIL sp_cycles: got %0d want 162", cyc); else n_pass++;
        n_total++; if (ready4 !== 1'b1) $display("FAIL sp_ready_with_done: got %b want 1", ready4); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (done4 !== 1'b0 || idle4 !== 1'b1) $display("FAIL sp_done_pulse: got done=%b idle=%b want 0 1", done4, idle4); else n_pass++;
        n_total++; if ($signed(mem4[3])  !== 9)   $display("FAIL sp_p03: got %0d want 9",   $signed(mem4[3]));  else n_pass++;
        n_total++; if ($signed(mem4[2])  !== 8)   $display("FAIL sp_p02: got %0d want 8",   $signed(mem4[2]));  else n_pass++;
        n_total++; if ($signed(mem4[7])  !== 4)   $display("FAIL sp_p13: got %0d want 4",   $signed(mem4[7]));  else n_pass++;
        n_total++; if ($signed(mem4[12]) !== 999) $display("FAIL sp_p30: got %0d want 999", $signed(mem4[12])); else n_pass++;
        n_total++; if ($signed(mem4[1])  !== 5)   $display("FAIL sp_p01: got %0d want 5",   $signed(mem4[1]));  else n_pass++;
        diffs = 0;
        for (int a = 0; a < 16; a++) if ($signed(mem4[a]) !== ref_m[a]) diffs++;
        n_total++; if (diffs !== 0) $display("FAIL sp_full_matrix: got %0d differing words want 0", diffs); else n_pass++;
        n_total++; if (wr_4 - w !== 64) $display("FAIL sp_writes: got %0d want 64", wr_4 - w); else n_pass++;
        n_total++; if (rd0_4 - r0 !== 80) $display("FAIL sp_port0_reads: got %0d want 80", rd0_4 - r0); else n_pass++;
        n_total++; if (rd1_4 - r1 !== 64) $display("FAIL sp_port1_reads: got %0d want 64", rd1_4 - r1); else n_pass++;
        n_total++; if (bad_4 - b !== 0) $display("FAIL sp_protocol: got %0d violations want 0", bad_4 - b); else n_pass++;
    endtask

    task automatic test_neg_self_loop();
        int cyc, w, diffs;
        load2(-1, 3, 2, 0);
        w = wr_2;
        run_pulse(1'b1, cyc);
        n_total++; if (cyc !== 26) $display("FAIL neg_cycles: got %0d want 26", cyc); else n_pass++;
        n_total++; if ($signed(mem2[0]) !== -2) $display("FAIL neg_p00: got %0d want -2", $signed(mem2[0])); else n_pass++;
        n_total++; if ($signed(mem2[1]) !== 1)  $display("FAIL neg_p01: got %0d want 1",  $signed(mem2[1])); else n_pass++;
        n_total++; if ($signed(mem2[2]) !== 0)  $display("FAIL neg_p10: got %0d want 0",  $signed(mem2[2])); else n_pass++;
        n_total++; if ($signed(mem2[3]) !== 0)  $display("FAIL neg_p11: got %0d want 0",  $signed(mem2[3])); else n_pass++;
        diffs = 0;
        for (int a = 0; a < 4; a++) if ($signed(mem2[a]) !== ref_m[a]) diffs++;
        n_total++; if (diffs !== 0) $display("FAIL neg_full_matrix: got %0d differing words want 0", diffs); else n_pass++;
        n_total++; if (wr_2 - w !== 8) $display("FAIL neg_writes: got %0d want 8", wr_2 - w); else n_pass++;
    endtask

    task automatic test_wrap();
        int cyc, b, diffs;
        load2(0, 32'h7FFF_FFFF, 1, 0);
        b = bad_2;
        run_pulse(1'b1, cyc);
        @(posedge clk); #1;
        n_total++; if (cyc !== 26) $display("FAIL wrap_cycles: got %0d want 26", cyc); else n_pass++;
        n_total++; if (mem2[0] !== 32'h8000_0000) $display("FAIL wrap_p00: got %h want 80000000", mem2[0]); else n_pass++;
        n_total++; if (mem2[1] !== 32'hFFFF_FFFF) $display("FAIL wrap_p01: got %h want ffffffff", mem2[1]); else n_pass++;
        n_total++; if (mem2[2] !== 32'h8000_0001) $display("FAIL wrap_p10: got %h want 80000001", mem2[2]); else n_pass++;
        n_total++; if (mem2[3] !== 32'h8000_0000) $display("FAIL wrap_p11: got %h want 80000000", mem2[3]); else n_pass++;
        diffs = 0;
        for (int a = 0; a < 4; a++) if ($signed(mem2[a]) !== ref_m[a]) diffs++;
        n_total++; if (diffs !== 0) $display("FAIL wrap_full_matrix: got %0d differing words want 0", diffs); else n_pass++;
        n_total++; if (bad_2 - b !== 0) $display("FAIL wrap_protocol: got %0d violations want 0", bad_2 - b); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int cyc, b, diffs;
        load_chain4();
        b = bad_4;
        start4 = 1'b1;
        @(posedge clk); #1;
        cyc = 2;
        while (done4 !== 1'b1 && cyc < BUDGET) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (done4 !== 1'b1) cyc = -1;
        n_total++; if (cyc !== 162) $display("FAIL b2b_first_cycles: got %0d want 162", cyc); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (idle4 !== 1'b1 || done4 !== 1'b0) $display("FAIL b2b_idle_between: got idle=%b done=%b want 1 0", idle4, done4); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (idle4 !== 1'b0 || ce0_4 !== 1'b1 || we0_4 !== 1'b0 || a0_4 !== 4'd0) $display("FAIL b2b_restart: got idle=%b ce0=%b we0=%b a0=%0d want 0 1 0 0", idle4, ce0_4, we0_4, a0_4); else n_pass++;
        // Dropping start mid-run must not stop the run.
        start4 = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        n_total++; if (idle4 !== 1'b0) $display("FAIL b2b_start_ignored: got idle=%b want 0", idle4); else n_pass++;
        // Asynchronous reset mid-run.
        rst = 1'b1;
        #1;
        n_total++; if (idle4 !== 1'b1 || {ce0_4, ce1_4, we0_4} !== 3'b000) $display("FAIL b2b_reset_immediate: got idle=%b ce/we=%b want 1 000", idle4, {ce0_4, ce1_4, we0_4}); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (idle4 !== 1'b1 || done4 !== 1'b0 || ce0_4 !== 1'b0) $display("FAIL b2b_after_reset: got idle=%b done=%b ce0=%b want 1 0 0", idle4, done4, ce0_4); else n_pass++;
        // The aborted run only rewrote already-converged values.
        diffs = 0;
        for (int a = 0; a < 16; a++) if ($signed(mem4[a]) !== ref_m[a]) diffs++;
        n_total++; if (diffs !== 0) $display("FAIL b2b_matrix_kept: got %0d differing words want 0", diffs); else n_pass++;
        n_total++; if (bad_4 - b !== 0) $display("FAIL b2b_protocol: got %0d violations want 0", bad_4 - b); else n_pass++;
    endtask

    initial begin
        rst    = 1'b1;
        start4 = 1'b0;
        start2 = 1'b0;
        test_reset();
        test_shortest_path();
        test_neg_self_loop();
        test_wrap();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
